// File: rtl/pc_sequencer_if.sv
// Bundle between control/ALU logic (master) and the LEGv8 program-counter unit (slave).
// Link/Ret/RasEmpty are only meaningful when the sequencer is built with PC_RAS_EN.
interface pc_sequencer_if #(
   parameter int WIDTH   = 64,
   parameter int COUNT_W = 16
);
   logic               Stall;
   logic               Branch;
   logic               ALUZero;
   logic               Uncondbranch;
   logic               RegBranch;
   logic [WIDTH-1:0]   SignExtImm;
   logic [WIDTH-1:0]   RegTarget;
   logic               Link;
   logic               Ret;
   logic [WIDTH-1:0]   CurrentPC;
   logic [WIDTH-1:0]   NextPC;
   logic               Taken;
   logic               AlignErr;
   logic [COUNT_W-1:0] TakenCount;
   logic               RasEmpty;

   modport master (
      output Stall, Branch, ALUZero, Uncondbranch, RegBranch, SignExtImm, RegTarget, Link, Ret,
      input  CurrentPC, NextPC, Taken, AlignErr, TakenCount, RasEmpty
   );

   modport slave (
      input  Stall, Branch, ALUZero, Uncondbranch, RegBranch, SignExtImm, RegTarget, Link, Ret,
      output CurrentPC, NextPC, Taken, AlignErr, TakenCount, RasEmpty
   );
endinterface

// File: rtl/pc_sequencer.sv
// LEGv8 program counter: next-PC select, stall hold, sticky misalignment flag, taken counter.
// Define PC_RAS_EN to add a circular return-address stack that predicts RET targets.
module pc_sequencer #(
   parameter int               WIDTH        = 64,
   parameter logic [WIDTH-1:0] RESET_PC     = '0,
   parameter int               OFFSET_SHIFT = 2,
   parameter int               COUNT_W      = 16,
   parameter int               RAS_DEPTH    = 4
) (
   input logic           CLK,
   input logic           Reset,
   pc_sequencer_if.slave bus
);

   logic [WIDTH-1:0]        r_pc;
   logic [COUNT_W-1:0]      r_count;
   logic                    r_align_err;

   logic signed [WIDTH-1:0] w_imm;
   logic signed [WIDTH-1:0] w_offset;
   logic [WIDTH-1:0]        w_pc_plus4;
   logic [WIDTH-1:0]        w_rel_target;
   logic [WIDTH-1:0]        w_reg_target;
   logic [WIDTH-1:0]        w_next;
   logic                    w_cond_taken;
   logic                    w_taken;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (&v) ? v : v + COUNT_W'(1);
   endfunction

   assign w_imm        = bus.SignExtImm;
   assign w_offset     = w_imm <<< OFFSET_SHIFT;
   assign w_pc_plus4   = r_pc + WIDTH'(4);
   assign w_rel_target = r_pc + $unsigned(w_offset);
   assign w_cond_taken = bus.Branch && bus.ALUZero;
   assign w_taken      = bus.RegBranch || bus.Uncondbranch || w_cond_taken;

`ifdef PC_RAS_EN
   localparam int              PTR_W     = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0]  DEPTH_CNT = RAS_DEPTH[PTR_W:0];

   logic [WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [PTR_W-1:0] r_top;
   logic [PTR_W:0]   r_ras_cnt;
   logic             w_ras_empty;
   logic             w_ras_hit;
   logic             w_pop;
   logic             w_push;
   logic [PTR_W-1:0] w_top_after_pop;
   logic [PTR_W-1:0] w_push_slot;

   assign w_ras_empty     = (r_ras_cnt == '0);
   assign w_ras_hit       = bus.RegBranch && bus.Ret && !w_ras_empty;
   assign w_pop           = w_ras_hit && !bus.Stall;
   assign w_push          = bus.Link && !bus.Stall;
   // Pop is applied before push, so a simultaneous BL/RET rewrites the current top slot.
   assign w_top_after_pop = w_pop ? r_top - PTR_W'(1) : r_top;
   assign w_push_slot     = w_top_after_pop + PTR_W'(1);
   assign w_reg_target    = w_ras_hit ? r_ras[r_top] : bus.RegTarget;
   assign bus.RasEmpty    = w_ras_empty;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_top     <= '0;
         r_ras_cnt <= '0;
      end else if (w_push) begin
         r_top <= w_push_slot;
         if (!w_pop && r_ras_cnt != DEPTH_CNT)
            r_ras_cnt <= r_ras_cnt + 1'b1;
      end else if (w_pop) begin
         r_top     <= w_top_after_pop;
         r_ras_cnt <= r_ras_cnt - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset && w_push)
         r_ras[w_push_slot] <= w_pc_plus4;
   end
`else
   logic w_unused_ras;

   assign w_unused_ras = bus.Link ^ bus.Ret;
   assign w_reg_target = bus.RegTarget;
   assign bus.RasEmpty = 1'b1;
`endif

   always_comb begin
      w_next = w_pc_plus4;
      if (bus.RegBranch)
         w_next = w_reg_target;
      else if (bus.Uncondbranch || w_cond_taken)
         w_next = w_rel_target;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_pc        <= RESET_PC;
         r_count     <= '0;
         r_align_err <= 1'b0;
      end else if (!bus.Stall) begin
         r_pc <= w_next;
         if (w_taken) begin
            r_count <= sat_inc(r_count);
            // Misaligned targets are loaded as-is; only the sticky flag records them.
            if (w_next[1:0] != 2'b00)
               r_align_err <= 1'b1;
         end
      end
   end

   assign bus.CurrentPC  = r_pc;
   assign bus.NextPC     = w_next;
   assign bus.Taken      = w_taken;
   assign bus.AlignErr   = r_align_err;
   assign bus.TakenCount = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push hand-computed expectations,
// a monitor checks combinational outputs mid-cycle and registered state after each edge.
module tb_pc_sequencer;

   localparam logic [63:0] M2 = 64'hFFFF_FFFF_FFFF_FFFE;
   localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] TOP4 = 64'hFFFF_FFFF_FFFF_FFFC;

   logic CLK;
   logic Reset;

   pc_sequencer_if #(.WIDTH(64), .COUNT_W(3)) bus ();

   pc_sequencer #(
      .WIDTH(64), .RESET_PC(64'h100), .OFFSET_SHIFT(2), .COUNT_W(3), .RAS_DEPTH(4)
   ) dut (
      .CLK(CLK), .Reset(Reset), .bus(bus)
   );

   typedef struct {
      string       name;
      bit          chk_comb;
      bit          taken;
      logic [63:0] next;
      logic [63:0] pc;
      logic [2:0]  cnt;
      bit          aerr;
      bit          re;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   passed = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Drive one cycle of inputs at the falling edge and queue what the DUT must show.
   task automatic vec(input string nm, input bit rst, st, br, zr, ub, rb, lk, rt,
                      input logic [63:0] imm, tgt,
                      input bit cc, tk, input logic [63:0] nx, pc,
                      input logic [2:0] cnt, input bit ae, re);
      exp_t x;
      @(negedge CLK);
      Reset = rst; bus.Stall = st; bus.Branch = br; bus.ALUZero = zr;
      bus.Uncondbranch = ub; bus.RegBranch = rb; bus.Link = lk; bus.Ret = rt;
      bus.SignExtImm = imm; bus.RegTarget = tgt;
      x.name = nm; x.chk_comb = cc; x.taken = tk; x.next = nx; x.pc = pc;
      x.cnt = cnt; x.aerr = ae; x.re = re;
      sb.push_back(x);
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_comb) begin
               chk({e.name, ".Taken"}, {63'd0, bus.Taken}, {63'd0, e.taken});
               chk({e.name, ".NextPC"}, bus.NextPC, e.next);
            end
            @(posedge CLK);
            #1;
            chk({e.name, ".CurrentPC"}, bus.CurrentPC, e.pc);
            chk({e.name, ".TakenCount"}, {61'd0, bus.TakenCount}, {61'd0, e.cnt});
            chk({e.name, ".AlignErr"}, {63'd0, bus.AlignErr}, {63'd0, e.aerr});
            chk({e.name, ".RasEmpty"}, {63'd0, bus.RasEmpty}, {63'd0, e.re});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("%0d/%0d checks passed", passed, total + 1);
      $finish;
   end

   initial begin
      Reset = 1'b1; bus.Stall = 0; bus.Branch = 0; bus.ALUZero = 0; bus.Uncondbranch = 0;
      bus.RegBranch = 0; bus.Link = 0; bus.Ret = 0; bus.SignExtImm = '0; bus.RegTarget = '0;

      //   name         rst st br zr ub rb lk rt imm     tgt       cc tk next     pc       cnt ae re
      vec("rst0",       1, 0, 0, 0, 0, 0, 0, 0, 0,      0,        0, 0, 0,       'h100,   0, 0, 1);
      vec("rst1",       1, 0, 0, 0, 0, 0, 0, 0, 0,      0,        0, 0, 0,       'h100,   0, 0, 1);
      vec("seq0",       0, 0, 0, 0, 0, 0, 0, 0, 0,      0,        1, 0, 'h104,   'h104,   0, 0, 1);
      vec("seq1",       0, 0, 0, 0, 0, 0, 0, 0, 0,      0,        1, 0, 'h108,   'h108,   0, 0, 1);
      vec("seq2",       0, 0, 0, 0, 0, 0, 0, 0, 0,      0,        1, 0, 'h10C,   'h10C,   0, 0, 1);
      vec("rstwin",     1, 1, 1, 1, 1, 1, 1, 0, 'h40,   'h200,    0, 0, 0,       'h100,   0, 0, 1);
      vec("b200",       0, 0, 0, 0, 1, 0, 0, 0, 'h40,   0,        1, 1, 'h200,   'h200,   1, 0, 1);
      vec("cbz_t",      0, 0, 1, 1, 0, 0, 0, 0, M2,     0,        1, 1, 'h1F8,   'h1F8,   2, 0, 1);
      vec("cbz_nt",     0, 0, 1, 0, 0, 0, 0, 0, M2,     0,        1, 0, 'h1FC,   'h1FC,   2, 0, 1);
      for (int i = 0; i < 3; i++)
         vec("stall",   0, 1, 0, 0, 1, 0, 0, 0, 4,      0,        1, 1, 'h20C,   'h1FC,   2, 0, 1);
      vec("unstall",    0, 0, 0, 0, 1, 0, 0, 0, 4,      0,        1, 1, 'h20C,   'h20C,   3, 0, 1);
      vec("stall_mis",  0, 1, 0, 0, 0, 1, 0, 0, 0,      'h301,    1, 1, 'h301,   'h20C,   3, 0, 1);
      vec("mis",        0, 0, 0, 0, 0, 1, 0, 0, 0,      'h302,    1, 1, 'h302,   'h302,   4, 1, 1);
      vec("mis_keep",   0, 0, 0, 0, 1, 0, 0, 0, 1,      0,        1, 1, 'h306,   'h306,   5, 1, 1);
      vec("prio",       0, 0, 1, 1, 1, 1, 0, 0, 'h10,   'h400,    1, 1, 'h400,   'h400,   6, 1, 1);
      vec("seq_ae",     0, 0, 0, 0, 0, 0, 0, 0, 0,      0,        1, 0, 'h404,   'h404,   6, 1, 1);
      vec("rst_clr",    1, 0, 0, 0, 0, 0, 0, 0, 0,      0,        0, 0, 0,       'h100,   0, 0, 1);
      vec("to_top",     0, 0, 0, 0, 0, 1, 0, 0, 0,      TOP4,     1, 1, TOP4,    TOP4,    1, 0, 1);
      vec("wrap",       0, 0, 0, 0, 0, 0, 0, 0, 0,      0,        1, 0, 0,       0,       1, 0, 1);
      vec("tk_plus4",   0, 0, 0, 0, 1, 0, 0, 0, 1,      0,        1, 1, 'h4,     'h4,     2, 0, 1);
      vec("b_neg",      0, 0, 0, 0, 1, 0, 0, 0, M1,     0,        1, 1, 0,       0,       3, 0, 1);
      vec("cbz_wrap",   0, 0, 1, 1, 0, 0, 0, 0, M1,     0,        1, 1, TOP4,    TOP4,    4, 0, 1);
`ifdef PC_RAS_EN
      vec("ras_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0,      0,        0, 0, 0,       'h100,   0, 0, 1);
      vec("ras_go400",  0, 0, 0, 0, 0, 1, 0, 0, 0,      'h400,    1, 1, 'h400,   'h400,   1, 0, 1);
      vec("bl1",        0, 0, 0, 0, 1, 0, 1, 0, 'h100,  0,        1, 1, 'h800,   'h800,   2, 0, 0);
      vec("bl2",        0, 0, 0, 0, 1, 0, 1, 0, 'h100,  0,        1, 1, 'hC00,   'hC00,   3, 0, 0);
      vec("ret1",       0, 0, 0, 0, 0, 1, 0, 1, 0,      0,        1, 1, 'h804,   'h804,   4, 0, 0);
      vec("ret2",       0, 0, 0, 0, 0, 1, 0, 1, 0,      0,        1, 1, 'h404,   'h404,   5, 0, 1);
      vec("ret3_empty", 0, 0, 0, 0, 0, 1, 0, 1, 0,      0,        1, 1, 0,       0,       6, 0, 1);
      for (int i = 1; i <= 5; i++)
         vec("push5",   0, 0, 0, 0, 0, 0, 1, 0, 0,      0,        1, 0, 64'(4*i), 64'(4*i), 6, 0, 0);
      vec("pop1",       0, 0, 0, 0, 0, 1, 0, 1, 0,      0,        1, 1, 'h14,    'h14,    7, 0, 0);
      vec("pop2",       0, 0, 0, 0, 0, 1, 0, 1, 0,      0,        1, 1, 'h10,    'h10,    7, 0, 0);
      vec("pop3",       0, 0, 0, 0, 0, 1, 0, 1, 0,      0,        1, 1, 'hC,     'hC,     7, 0, 0);
      vec("pop4",       0, 0, 0, 0, 0, 1, 0, 1, 0,      0,        1, 1, 'h8,     'h8,     7, 0, 1);
      vec("pop5_empty", 0, 0, 0, 0, 0, 1, 0, 1, 0,      'h50,     1, 1, 'h50,    'h50,    7, 0, 1);
      vec("lk_a",       0, 0, 0, 0, 0, 0, 1, 0, 0,      0,        1, 0, 'h54,    'h54,    7, 0, 0);
      vec("lk_b",       0, 0, 0, 0, 0, 0, 1, 0, 0,      0,        1, 0, 'h58,    'h58,    7, 0, 0);
      vec("lk_ret",     0, 0, 0, 0, 0, 1, 1, 1, 0,      0,        1, 1, 'h58,    'h58,    7, 0, 0);
      vec("ret_new",    0, 0, 0, 0, 0, 1, 0, 1, 0,      0,        1, 1, 'h5C,    'h5C,    7, 0, 0);
      vec("ret_old",    0, 0, 0, 0, 0, 1, 0, 1, 0,      0,        1, 1, 'h54,    'h54,    7, 0, 1);
`else
      vec("noras_ret",  0, 0, 0, 0, 0, 1, 1, 1, 0,      'h500,    1, 1, 'h500,   'h500,   5, 0, 1);
      vec("noras_lk",   0, 0, 0, 0, 0, 0, 1, 0, 0,      0,        1, 0, 'h504,   'h504,   5, 0, 1);
`endif
      vec("sat_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0,      0,        0, 0, 0,       'h100,   0, 0, 1);
      for (int i = 1; i <= 8; i++)
         vec("sat",     0, 0, 0, 0, 1, 0, 0, 0, 1,      0,        1, 1, 64'('h100 + 4*i), 64'('h100 + 4*i),
             (i > 7) ? 3'd7 : 3'(i), 0, 1);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
      repeat (2) @(negedge CLK);
      if (sb.size() != 0) begin
         total++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
